// File: rtl/ascon_pack.sv
// Shared ASCON constants and types used by the output buffer.
package ascon_pack;

  localparam int BLOCK_WIDTH    = 128;
  localparam int BLOCK_BYTES    = BLOCK_WIDTH / 8;
  localparam int BYTE_CNT_WIDTH = $clog2(BLOCK_BYTES) + 1;

  typedef enum logic {
    OUT_IDLE,
    OUT_SEND
  } out_state_e;

  // Byte counts above one block are clamped to a full block.
  function automatic logic [BYTE_CNT_WIDTH-1:0] sat_bytes(input logic [BYTE_CNT_WIDTH-1:0] b);
    return (b > BYTE_CNT_WIDTH'(BLOCK_BYTES)) ? BYTE_CNT_WIDTH'(BLOCK_BYTES) : b;
  endfunction

endpackage

// File: rtl/ascon_strb_gen.sv
// Byte strobe mask for one output word: MSB strobe is the first byte of the word.
module ascon_strb_gen
  import ascon_pack::*;
#(
  parameter int WORD_BYTES = 4
) (
  input  logic [BYTE_CNT_WIDTH-1:0] bytes_rem,
  output logic [WORD_BYTES-1:0]     strb
);

  always_comb begin
    strb = '0;
    for (int k = 0; k < WORD_BYTES; k++) begin
      strb[WORD_BYTES-1-k] = (BYTE_CNT_WIDTH'(k) < bytes_rem);
    end
  end

endmodule

// File: rtl/ascon_output_buffer.sv
// Serialises one 128-bit ASCON block onto a WORD_WIDTH stream with byte strobes.
// Optional: define ASCON_OUT_ZEROIZE_EN to clear held data after the final word.
module ascon_output_buffer
  import ascon_pack::*;
#(
  parameter int WORD_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      blk_valid_i,
  output logic                      blk_ready_o,
  input  logic [BLOCK_WIDTH-1:0]    blk_data_i,
  input  logic [BYTE_CNT_WIDTH-1:0] blk_bytes_i,
  input  logic                      blk_last_i,
  output logic                      word_valid_o,
  input  logic                      word_ready_i,
  output logic [WORD_WIDTH-1:0]     word_data_o,
  output logic [WORD_WIDTH/8-1:0]   word_strb_o,
  output logic                      word_last_o,
  output logic                      busy_o
);

  localparam int WORD_BYTES = WORD_WIDTH / 8;
  localparam logic [BYTE_CNT_WIDTH-1:0] WORD_BYTES_C  = BYTE_CNT_WIDTH'(WORD_BYTES);
  localparam logic [BYTE_CNT_WIDTH-1:0] WORD_BYTES_M1 = BYTE_CNT_WIDTH'(WORD_BYTES - 1);
  localparam logic [BYTE_CNT_WIDTH-1:0] ONE_C         = BYTE_CNT_WIDTH'(1);

  out_state_e                state_q, state_d;
  logic [BLOCK_WIDTH-1:0]    shift_q, blk_masked;
  logic [BYTE_CNT_WIDTH-1:0] bytes_rem_q, words_rem_q;
  logic [BYTE_CNT_WIDTH-1:0] cap_bytes, cap_words, word_take;
  logic                      last_q;
  logic                      blk_hs, cap_go, word_hs, final_hs;
  logic [WORD_BYTES-1:0]     strb_mask;

  assign blk_ready_o  = !rst && (state_q == OUT_IDLE);
  assign word_valid_o = (state_q == OUT_SEND);
  assign busy_o       = (state_q == OUT_SEND);

  assign blk_hs   = blk_valid_i && blk_ready_o;
  assign word_hs  = word_valid_o && word_ready_i;
  assign final_hs = word_hs && (words_rem_q == ONE_C);
  // An empty non-final block carries nothing and is consumed without a transfer.
  assign cap_go   = blk_hs && ((cap_bytes != '0) || blk_last_i);

  always_comb begin
    cap_bytes  = sat_bytes(blk_bytes_i);
    cap_words  = (cap_bytes == '0) ? ONE_C : (cap_bytes + WORD_BYTES_M1) / WORD_BYTES_C;
    blk_masked = blk_data_i;
    for (int i = 0; i < BLOCK_BYTES; i++) begin
      if (BYTE_CNT_WIDTH'(i) >= cap_bytes) blk_masked[BLOCK_WIDTH-1-8*i -: 8] = 8'h00;
    end
  end

  assign word_take = (bytes_rem_q < WORD_BYTES_C) ? bytes_rem_q : WORD_BYTES_C;

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      OUT_IDLE: if (cap_go)   state_d = OUT_SEND;
      OUT_SEND: if (final_hs) state_d = OUT_IDLE;
      default:                state_d = OUT_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) state_q <= OUT_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the data register is reset too, so no earlier block survives a reset.
      shift_q     <= '0;
      bytes_rem_q <= '0;
      words_rem_q <= '0;
      last_q      <= 1'b0;
    end else if (cap_go) begin
      shift_q     <= blk_masked;
      bytes_rem_q <= cap_bytes;
      words_rem_q <= cap_words;
      last_q      <= blk_last_i;
    end else if (word_hs) begin
`ifdef ASCON_OUT_ZEROIZE_EN
      shift_q     <= final_hs ? '0 : (shift_q << WORD_WIDTH);
`else
      shift_q     <= shift_q << WORD_WIDTH;
`endif
      bytes_rem_q <= bytes_rem_q - word_take;
      words_rem_q <= words_rem_q - ONE_C;
    end
  end

  ascon_strb_gen #(.WORD_BYTES(WORD_BYTES)) u_strb_gen (
    .bytes_rem (bytes_rem_q),
    .strb      (strb_mask)
  );

  assign word_strb_o = word_valid_o ? strb_mask : '0;
  assign word_last_o = word_valid_o && last_q && (words_rem_q == ONE_C);

`ifdef ASCON_OUT_ZEROIZE_EN
  assign word_data_o = word_valid_o ? shift_q[BLOCK_WIDTH-1 -: WORD_WIDTH] : '0;
`else
  assign word_data_o = shift_q[BLOCK_WIDTH-1 -: WORD_WIDTH];
`endif

endmodule

// File: tb/tb_ascon_output_buffer.sv
// Self-checking bench for ascon_output_buffer: byte-level model plus directed blocks.
module tb_ascon_output_buffer;

  localparam int WW = 32;
  localparam int WB = WW / 8;

  typedef struct {
    logic [WW-1:0] data;
    logic [WB-1:0] strb;
    logic          last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          blk_valid_i;
  logic          blk_ready_o;
  logic [127:0]  blk_data_i;
  logic [4:0]    blk_bytes_i;
  logic          blk_last_i;
  logic          word_valid_o;
  logic          word_ready_i;
  logic [WW-1:0] word_data_o;
  logic [WB-1:0] word_strb_o;
  logic          word_last_o;
  logic          busy_o;

  int checks   = 0;
  int failures = 0;
  int hs_count = 0;
  int stall_checks = 0;
  int blk_busy_cycles = 0;
  logic [WW-1:0] last_data;
  logic [WB-1:0] last_strb;

  exp_t exp_q[$];
  bit   rdy_pat[$];
  bit   next_pat[$];

  localparam logic [127:0] D0 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] D1 = 128'hDEADBEEF_01234567_89ABCDEF_F0E1D2C3;

  always #5 clk = ~clk;

  ascon_output_buffer #(.WORD_WIDTH(WW)) dut (
    .clk          (clk),
    .rst          (rst),
    .blk_valid_i  (blk_valid_i),
    .blk_ready_o  (blk_ready_o),
    .blk_data_i   (blk_data_i),
    .blk_bytes_i  (blk_bytes_i),
    .blk_last_i   (blk_last_i),
    .word_valid_o (word_valid_o),
    .word_ready_i (word_ready_i),
    .word_data_o  (word_data_o),
    .word_strb_o  (word_strb_o),
    .word_last_o  (word_last_o),
    .busy_o       (busy_o)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected words derived byte by byte from the block contents.
  task automatic model_block(input logic [127:0] data, input int bytes, input bit last);
    int   n, nw, idx;
    exp_t e;
    n = (bytes > 16) ? 16 : bytes;
    if (n == 0) begin
      if (last) exp_q.push_back('{data: '0, strb: '0, last: 1'b1});
      return;
    end
    nw = (n + WB - 1) / WB;
    for (int w = 0; w < nw; w++) begin
      e.data = '0;
      e.strb = '0;
      for (int b = 0; b < WB; b++) begin
        idx = w * WB + b;
        if (idx < n) begin
          e.data[WW-1-8*b -: 8] = data[127-8*idx -: 8];
          e.strb[WB-1-b] = 1'b1;
        end
      end
      e.last = last && (w == nw - 1);
      exp_q.push_back(e);
    end
  endtask

  always @(posedge clk) begin
    #1;
    word_ready_i = (rdy_pat.size() > 0) ? rdy_pat.pop_front() : 1'b1;
  end

  // Compare process: every handshake against the model, stability during stalls.
  logic          stall_f = 1'b0;
  logic [WW-1:0] s_data;
  logic [WB-1:0] s_strb;
  logic          s_last;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      stall_f = 1'b0;
    end else begin
      if (!blk_ready_o) blk_busy_cycles++;
      check("busy_eq_valid", busy_o, word_valid_o);
      if (stall_f) begin
        stall_checks++;
        check("stall_valid", word_valid_o, 1'b1);
        check("stall_data", word_data_o, s_data);
        check("stall_strb", word_strb_o, s_strb);
        check("stall_last", word_last_o, s_last);
      end
      stall_f = word_valid_o && !word_ready_i;
      s_data = word_data_o;
      s_strb = word_strb_o;
      s_last = word_last_o;
      if (word_valid_o && word_ready_i) begin
        hs_count++;
        last_data = word_data_o;
        last_strb = word_strb_o;
        if (exp_q.size() == 0) begin
          check("unexpected_word", word_valid_o, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("word_data", word_data_o, e.data);
          check("word_strb", word_strb_o, e.strb);
          check("word_last", word_last_o, e.last);
        end
      end
    end
  end

  task automatic send_block(input logic [127:0] data, input int bytes, input bit last);
    int k;
    @(posedge clk); #1;
    blk_valid_i = 1'b1;
    blk_data_i  = data;
    blk_bytes_i = 5'(bytes);
    blk_last_i  = last;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (blk_ready_o) break;
    end
    check("blk_accept_timeout", (k < 50), 1'b1);
    model_block(data, bytes, last);
    rdy_pat = next_pat;
    next_pat.delete();
    @(posedge clk); #1;
    blk_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !word_valid_o) break;
    end
    check("drain_timeout", (k < 100), 1'b1);
    check("model_drained", exp_q.size(), 0);
  endtask

  initial begin
    int h0, k;
    rst = 1'b1; blk_valid_i = 1'b0; blk_data_i = '0; blk_bytes_i = '0; blk_last_i = 1'b0;
    word_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_blk_ready", blk_ready_o, 1'b0);
    check("rst_valid", word_valid_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_data", word_data_o, 32'h0);
    check("rst_strb", word_strb_o, 4'h0);
    check("rst_last", word_last_o, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_blk_ready", blk_ready_o, 1'b1);

    // Full block
    h0 = hs_count; blk_busy_cycles = 0;
    send_block(D0, 16, 1'b1);
    @(negedge clk);
    check("t1_first_valid", word_valid_o, 1'b1);
    check("t1_first_data", word_data_o, 32'h00112233);
    check("t1_first_strb", word_strb_o, 4'hF);
    wait_idle();
    check("t1_words", hs_count - h0, 4);
    check("t1_last_data", last_data, 32'hCCDDEEFF);
    check("t1_blk_ready_low", blk_busy_cycles, 4);

    // Partial block
    h0 = hs_count;
    send_block(D0, 6, 1'b1);
    wait_idle();
    check("t2_words", hs_count - h0, 2);
    check("t2_last_data", last_data, 32'h44550000);
    check("t2_last_strb", last_strb, 4'hC);

    // Backpressure
    h0 = hs_count; k = stall_checks;
    next_pat = '{0, 0, 1, 0, 1, 1, 1};
    send_block(D0, 16, 1'b1);
    wait_idle();
    check("t3_words", hs_count - h0, 4);
    check("t3_stall_cycles", stall_checks - k, 3);

    // Empty final block
    h0 = hs_count;
    send_block(D1, 0, 1'b1);
    @(negedge clk);
    check("t4_empty_valid", word_valid_o, 1'b1);
    check("t4_empty_strb", word_strb_o, 4'h0);
    check("t4_empty_last", word_last_o, 1'b1);
    wait_idle();
    check("t4_empty_words", hs_count - h0, 1);

    // Empty non-final block is dropped
    h0 = hs_count;
    send_block(D1, 0, 1'b0);
    @(negedge clk);
    check("t4_drop_valid", word_valid_o, 1'b0);
    check("t4_drop_ready", blk_ready_o, 1'b1);
    repeat (3) @(negedge clk);
    check("t4_drop_words", hs_count - h0, 0);

    // Assorted sizes
    send_block(D1, 1, 1'b0);  wait_idle();
    check("t_b1_data", last_data, 32'hDE000000);
    send_block(D1, 13, 1'b0); wait_idle();
    send_block(D1, 8, 1'b1);  wait_idle();
    check("t_b8_data", last_data, 32'h01234567);

    // Mid-transfer reset
    h0 = hs_count;
    send_block(D0, 16, 1'b1);
    for (k = 0; k < 50; k++) begin
      if (hs_count - h0 >= 2) break;
      @(negedge clk);
    end
    check("t5_wait_timeout", (k < 50), 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    check("t5_valid", word_valid_o, 1'b0);
    check("t5_data", word_data_o, 32'h0);
    check("t5_strb", word_strb_o, 4'h0);
    check("t5_last", word_last_o, 1'b0);
    check("t5_busy", busy_o, 1'b0);
    check("t5_blk_ready", blk_ready_o, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    h0 = hs_count;
    send_block(D1, 16, 1'b1);
    wait_idle();
    check("t5_after_words", hs_count - h0, 4);
    check("t5_after_last", last_data, 32'hF0E1D2C3);

    // Saturation
    h0 = hs_count;
    send_block(D0, 20, 1'b1);
    wait_idle();
    check("t6_sat_words", hs_count - h0, 4);
    check("t6_sat_last", last_data, 32'hCCDDEEFF);
`ifdef ASCON_OUT_ZEROIZE_EN
    @(negedge clk);
    check("t6_zero_reg", dut.shift_q, 128'h0);
    check("t6_zero_data", word_data_o, 32'h0);
`endif

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
